// File: rtl/arm7tdmi_banked_regfile.sv
// arm7tdmi_banked_regfile
// Architectural register state of the ARM7TDMI: banked general registers,
// PC, CPSR and five SPSRs. Two zero-latency read ports, one write port,
// plus dedicated PC / CPSR / SPSR / mode-change update paths.
//
// Build option: define ARM7_FIQ_BANK_EN to give FIQ private R8-R14.
// Without it, FIQ banks only R13-R14 and shares R8-R12 with USER.

module arm7tdmi_banked_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rn_addr,
    input  logic [3:0]  rm_addr,
    output logic [31:0] rn_data,
    output logic [31:0] rm_data,
    input  logic [3:0]  rd_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_we,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_in,
    input  logic        pc_we,
    input  logic [4:0]  current_mode,
    input  logic [4:0]  target_mode,
    input  logic        mode_change,
    output logic [31:0] cpsr_out,
    input  logic [31:0] cpsr_in,
    input  logic        cpsr_we,
    output logic [31:0] spsr_out,
    input  logic [31:0] spsr_in,
    input  logic        spsr_we
);

    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } processor_mode_t;

    // Bank index: 0 = USER/SYS (and any unknown encoding), 1..5 = FIQ..UND.
    // Banks 1..5 map to entry (bank - 1) of the banked SP/LR and SPSR arrays.
    localparam logic [2:0] BANK_USR = 3'd0;
    localparam logic [2:0] BANK_FIQ = 3'd1;
    localparam logic [2:0] BANK_IRQ = 3'd2;
    localparam logic [2:0] BANK_SVC = 3'd3;
    localparam logic [2:0] BANK_ABT = 3'd4;
    localparam logic [2:0] BANK_UND = 3'd5;

    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    // USER/SYS R0-R14
    logic [31:0] usr_r [0:14];
    // R13/R14 of FIQ, IRQ, SVC, ABT, UND; inner index 0 = R13, 1 = R14
    logic [31:0] sp_bank_r [0:4][0:1];
`ifdef ARM7_FIQ_BANK_EN
    // FIQ private R8-R12
    logic [31:0] fiq_lo_r [0:4];
`endif
    logic [31:0] spsr_r [0:4];
    logic [31:0] pc_r;
    logic [31:0] cpsr_r;

    logic [2:0]  cur_bank_s;
    logic [2:0]  cur_idx_s;

    function automatic logic [2:0] mode_bank(input logic [4:0] mode);
        logic [2:0] bank;
        case (mode)
            MODE_FIQ: bank = BANK_FIQ;
            MODE_IRQ: bank = BANK_IRQ;
            MODE_SVC: bank = BANK_SVC;
            MODE_ABT: bank = BANK_ABT;
            MODE_UND: bank = BANK_UND;
            default:  bank = BANK_USR;
        endcase
        return bank;
    endfunction

    // Resolves a register index against the given bank to its physical storage.
    function automatic logic [31:0] read_reg(input logic [3:0] addr, input logic [2:0] bank);
        logic [31:0] val;
        logic [2:0]  idx;
`ifdef ARM7_FIQ_BANK_EN
        logic [3:0]  off;
        off = addr - 4'd8;
`endif
        idx = bank - 3'd1;
        val = 32'h0000_0000;
        if (addr == 4'd15) begin
            val = pc_r;
        end else if ((bank != BANK_USR) && (addr >= 4'd13)) begin
            val = sp_bank_r[idx][~addr[0]];
`ifdef ARM7_FIQ_BANK_EN
        end else if ((bank == BANK_FIQ) && (addr >= 4'd8)) begin
            val = fiq_lo_r[off[2:0]];
`endif
        end else begin
            val = usr_r[addr];
        end
        return val;
    endfunction

    // Decode the active bank from current_mode.
    always_comb begin
        cur_bank_s = mode_bank(current_mode);
        cur_idx_s  = cur_bank_s - 3'd1;
    end

    // Zero-latency read ports; no bypass of same-cycle writes.
    always_comb begin
        rn_data = read_reg(rn_addr, cur_bank_s);
        rm_data = read_reg(rm_addr, cur_bank_s);
    end

    // SPSR view: USER/SYS have no SPSR, so they see the CPSR.
    always_comb begin
        spsr_out = 32'h0000_0000;
        if (cur_bank_s == BANK_USR) begin
            spsr_out = cpsr_r;
        end else begin
            spsr_out = spsr_r[cur_idx_s];
        end
    end

    assign pc_out   = pc_r;
    assign cpsr_out = cpsr_r;

    // General-register writeback into the bank selected by current_mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                usr_r[i] <= 32'h0000_0000;
            end
            for (int b = 0; b < 5; b++) begin
                sp_bank_r[b][0] <= 32'h0000_0000;
                sp_bank_r[b][1] <= 32'h0000_0000;
            end
`ifdef ARM7_FIQ_BANK_EN
            for (int j = 0; j < 5; j++) begin
                fiq_lo_r[j] <= 32'h0000_0000;
            end
`endif
        end else if (rd_we && (rd_addr != 4'd15)) begin
            if ((cur_bank_s != BANK_USR) && (rd_addr >= 4'd13)) begin
                sp_bank_r[cur_idx_s][~rd_addr[0]] <= rd_data;
`ifdef ARM7_FIQ_BANK_EN
            end else if ((cur_bank_s == BANK_FIQ) && (rd_addr >= 4'd8)) begin
                fiq_lo_r[rd_addr[2:0]] <= rd_data;
`endif
            end else begin
                usr_r[rd_addr] <= rd_data;
            end
        end
    end

    // PC update: dedicated pc_we path has priority over a writeback to R15.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= 32'h0000_0000;
        end else if (pc_we) begin
            pc_r <= pc_in;
        end else if (rd_we && (rd_addr == 4'd15)) begin
            pc_r <= rd_data;
        end
    end

    // CPSR update: mode_change always owns the mode field when asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr_r <= CPSR_RESET;
        end else if (cpsr_we) begin
            cpsr_r <= {cpsr_in[31:5], (mode_change ? target_mode : cpsr_in[4:0])};
        end else if (mode_change) begin
            cpsr_r[4:0] <= target_mode;
        end
    end

    // SPSR write for the current exception mode; ignored in USER/SYS.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 5; k++) begin
                spsr_r[k] <= 32'h0000_0000;
            end
        end else if (spsr_we && (cur_bank_s != BANK_USR)) begin
            spsr_r[cur_idx_s] <= spsr_in;
        end
    end

endmodule

// File: tb/tb_arm7tdmi_banked_regfile.sv
// Directed, table-driven bench for arm7tdmi_banked_regfile.
module tb_arm7tdmi_banked_regfile;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_SYS = 5'b11111;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rn_addr, rm_addr, rd_addr;
    logic [31:0] rn_data, rm_data, rd_data;
    logic        rd_we;
    logic [31:0] pc_out, pc_in;
    logic        pc_we;
    logic [4:0]  current_mode, target_mode;
    logic        mode_change;
    logic [31:0] cpsr_out, cpsr_in;
    logic        cpsr_we;
    logic [31:0] spsr_out, spsr_in;
    logic        spsr_we;

    int checks = 0;
    int errors = 0;

    arm7tdmi_banked_regfile dut (
        .clk(clk), .rst(rst),
        .rn_addr(rn_addr), .rm_addr(rm_addr), .rn_data(rn_data), .rm_data(rm_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
        .pc_out(pc_out), .pc_in(pc_in), .pc_we(pc_we),
        .current_mode(current_mode), .target_mode(target_mode), .mode_change(mode_change),
        .cpsr_out(cpsr_out), .cpsr_in(cpsr_in), .cpsr_we(cpsr_we),
        .spsr_out(spsr_out), .spsr_in(spsr_in), .spsr_we(spsr_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  mode;
        logic        rd_we;
        logic [3:0]  rd_addr;
        logic [31:0] rd_data;
        logic        pc_we;
        logic [31:0] pc_in;
        logic        cpsr_we;
        logic [31:0] cpsr_in;
        logic        mode_change;
        logic [4:0]  target_mode;
        logic        spsr_we;
        logic [31:0] spsr_in;
        logic [4:0]  read_mode;
        logic [3:0]  rn_addr;
        logic [3:0]  rm_addr;
        logic [31:0] exp_rn;
        logic [31:0] exp_rm;
        logic [31:0] exp_pc;
        logic [31:0] exp_cpsr;
        logic [31:0] exp_spsr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t blank(input string name, input logic [4:0] mode);
        vec_t t;
        t.name = name; t.rst = 1'b0; t.mode = mode;
        t.rd_we = 1'b0; t.rd_addr = 4'd0; t.rd_data = 32'h0;
        t.pc_we = 1'b0; t.pc_in = 32'h0;
        t.cpsr_we = 1'b0; t.cpsr_in = 32'h0;
        t.mode_change = 1'b0; t.target_mode = 5'd0;
        t.spsr_we = 1'b0; t.spsr_in = 32'h0;
        t.read_mode = mode; t.rn_addr = 4'd0; t.rm_addr = 4'd0;
        t.exp_rn = 32'h0; t.exp_rm = 32'h0; t.exp_pc = 32'h0;
        t.exp_cpsr = 32'h0; t.exp_spsr = 32'h0;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rd_we = 1'b0; pc_we = 1'b0; cpsr_we = 1'b0;
        mode_change = 1'b0; spsr_we = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; current_mode = v.mode;
        rd_we = v.rd_we; rd_addr = v.rd_addr; rd_data = v.rd_data;
        pc_we = v.pc_we; pc_in = v.pc_in;
        cpsr_we = v.cpsr_we; cpsr_in = v.cpsr_in;
        mode_change = v.mode_change; target_mode = v.target_mode;
        spsr_we = v.spsr_we; spsr_in = v.spsr_in;
        @(posedge clk);
        #1;
        idle_inputs();
        current_mode = v.read_mode; rn_addr = v.rn_addr; rm_addr = v.rm_addr;
        #1;
        check({v.name, ".rn"},   rn_data,  v.exp_rn);
        check({v.name, ".rm"},   rm_data,  v.exp_rm);
        check({v.name, ".pc"},   pc_out,   v.exp_pc);
        check({v.name, ".cpsr"}, cpsr_out, v.exp_cpsr);
        check({v.name, ".spsr"}, spsr_out, v.exp_spsr);
    endtask

    initial begin
        vec_t t;
        logic [31:0] usr_r8_exp;
`ifdef ARM7_FIQ_BANK_EN
        usr_r8_exp = 32'h0;
`else
        usr_r8_exp = 32'h0000_AAAA;
`endif
        idle_inputs();
        current_mode = M_USR; target_mode = 5'd0;
        rn_addr = 4'd0; rm_addr = 4'd0; rd_addr = 4'd0; rd_data = 32'h0;
        pc_in = 32'h0; cpsr_in = 32'h0; spsr_in = 32'h0;

        // reset with a competing write: reset must win
        t = blank("reset", M_USR); t.rst = 1'b1; t.rd_we = 1'b1; t.rd_data = 32'hDEAD;
        t.pc_we = 1'b1; t.pc_in = 32'h44; t.rm_addr = 4'd15;
        t.exp_cpsr = 32'hD3; t.exp_spsr = 32'hD3; vecs.push_back(t);

        t = blank("usr_r1", M_USR); t.rd_we = 1'b1; t.rd_addr = 4'd1; t.rd_data = 32'h1234_5678;
        t.rn_addr = 4'd1; t.rm_addr = 4'd2; t.exp_rn = 32'h1234_5678;
        t.exp_cpsr = 32'hD3; t.exp_spsr = 32'hD3; vecs.push_back(t);

        t = blank("usr_r13", M_USR); t.rd_we = 1'b1; t.rd_addr = 4'd13; t.rd_data = 32'h1000;
        t.rn_addr = 4'd13; t.rm_addr = 4'd1; t.exp_rn = 32'h1000; t.exp_rm = 32'h1234_5678;
        t.exp_cpsr = 32'hD3; t.exp_spsr = 32'hD3; vecs.push_back(t);

        t = blank("irq_r13", M_IRQ); t.rd_we = 1'b1; t.rd_addr = 4'd13; t.rd_data = 32'h2000;
        t.rn_addr = 4'd13; t.rm_addr = 4'd14; t.exp_rn = 32'h2000;
        t.exp_cpsr = 32'hD3; t.exp_spsr = 32'h0; vecs.push_back(t);

        t = blank("usr_r13_kept", M_USR); t.rn_addr = 4'd13; t.rm_addr = 4'd14;
        t.exp_rn = 32'h1000; t.exp_cpsr = 32'hD3; t.exp_spsr = 32'hD3; vecs.push_back(t);

        t = blank("fiq_r8", M_FIQ); t.rd_we = 1'b1; t.rd_addr = 4'd8; t.rd_data = 32'h0000_AAAA;
        t.read_mode = M_USR; t.rn_addr = 4'd8; t.rm_addr = 4'd9; t.exp_rn = usr_r8_exp;
        t.exp_cpsr = 32'hD3; t.exp_spsr = 32'hD3; vecs.push_back(t);

        t = blank("fiq_view", M_FIQ); t.rn_addr = 4'd8; t.rm_addr = 4'd13;
        t.exp_rn = 32'h0000_AAAA; t.exp_cpsr = 32'hD3; t.exp_spsr = 32'h0; vecs.push_back(t);

        t = blank("cpsr_wr", M_USR); t.cpsr_we = 1'b1; t.cpsr_in = 32'h6000_0010;
        t.rn_addr = 4'd1; t.exp_rn = 32'h1234_5678;
        t.exp_cpsr = 32'h6000_0010; t.exp_spsr = 32'h6000_0010; vecs.push_back(t);

        t = blank("cpsr_wr_mc", M_USR); t.cpsr_we = 1'b1; t.cpsr_in = 32'h6000_0010;
        t.mode_change = 1'b1; t.target_mode = M_SVC;
        t.exp_cpsr = 32'h6000_0013; t.exp_spsr = 32'h6000_0013; vecs.push_back(t);

        t = blank("mc_only", M_USR); t.mode_change = 1'b1; t.target_mode = M_IRQ; t.cpsr_in = 32'hFFFF_FFFF;
        t.exp_cpsr = 32'h6000_0012; t.exp_spsr = 32'h6000_0012; vecs.push_back(t);

        t = blank("svc_spsr", M_SVC); t.spsr_we = 1'b1; t.spsr_in = 32'hA000_0010;
        t.exp_cpsr = 32'h6000_0012; t.exp_spsr = 32'hA000_0010; vecs.push_back(t);

        t = blank("usr_spsr_ign", M_USR); t.spsr_we = 1'b1; t.spsr_in = 32'h5555_5555;
        t.exp_cpsr = 32'h6000_0012; t.exp_spsr = 32'h6000_0012; vecs.push_back(t);

        t = blank("svc_spsr_kept", M_SVC); t.rn_addr = 4'd13; t.rm_addr = 4'd1;
        t.exp_rm = 32'h1234_5678; t.exp_cpsr = 32'h6000_0012; t.exp_spsr = 32'hA000_0010; vecs.push_back(t);

        t = blank("pc_prio", M_USR); t.pc_we = 1'b1; t.pc_in = 32'h100;
        t.rd_we = 1'b1; t.rd_addr = 4'd15; t.rd_data = 32'h200;
        t.rn_addr = 4'd15; t.rm_addr = 4'd15; t.exp_rn = 32'h100; t.exp_rm = 32'h100;
        t.exp_pc = 32'h100; t.exp_cpsr = 32'h6000_0012; t.exp_spsr = 32'h6000_0012; vecs.push_back(t);

        t = blank("rd_r15", M_USR); t.rd_we = 1'b1; t.rd_addr = 4'd15; t.rd_data = 32'h300;
        t.rn_addr = 4'd15; t.rm_addr = 4'd1; t.exp_rn = 32'h300; t.exp_rm = 32'h1234_5678;
        t.exp_pc = 32'h300; t.exp_cpsr = 32'h6000_0012; t.exp_spsr = 32'h6000_0012; vecs.push_back(t);

        t = blank("all_writes", M_IRQ); t.rd_we = 1'b1; t.rd_addr = 4'd2; t.rd_data = 32'h22;
        t.spsr_we = 1'b1; t.spsr_in = 32'h11; t.cpsr_we = 1'b1; t.cpsr_in = 32'hF000_00DF;
        t.rn_addr = 4'd2; t.rm_addr = 4'd13; t.exp_rn = 32'h22; t.exp_rm = 32'h2000;
        t.exp_pc = 32'h300; t.exp_cpsr = 32'hF000_00DF; t.exp_spsr = 32'h11; vecs.push_back(t);

        t = blank("bad_mode", 5'b00000); t.rd_we = 1'b1; t.rd_addr = 4'd13; t.rd_data = 32'h77;
        t.read_mode = M_USR; t.rn_addr = 4'd13; t.rm_addr = 4'd2; t.exp_rn = 32'h77; t.exp_rm = 32'h22;
        t.exp_pc = 32'h300; t.exp_cpsr = 32'hF000_00DF; t.exp_spsr = 32'hF000_00DF; vecs.push_back(t);

        t = blank("sys_r14", M_SYS); t.rd_we = 1'b1; t.rd_addr = 4'd14; t.rd_data = 32'hE;
        t.read_mode = M_USR; t.rn_addr = 4'd14; t.rm_addr = 4'd13; t.exp_rn = 32'hE; t.exp_rm = 32'h77;
        t.exp_pc = 32'h300; t.exp_cpsr = 32'hF000_00DF; t.exp_spsr = 32'hF000_00DF; vecs.push_back(t);

        t = blank("reset2", M_IRQ); t.rst = 1'b1; t.rd_we = 1'b1; t.rd_addr = 4'd5; t.rd_data = 32'h5;
        t.cpsr_we = 1'b1; t.cpsr_in = 32'h1F; t.spsr_we = 1'b1; t.spsr_in = 32'h99;
        t.rn_addr = 4'd13; t.rm_addr = 4'd5; t.exp_cpsr = 32'hD3; t.exp_spsr = 32'h0; vecs.push_back(t);

        apply(vecs[0]);
        // full post-reset sweep of both read ports in USER
        current_mode = M_USR;
        for (int i = 0; i < 16; i++) begin
            rn_addr = i[3:0];
            rm_addr = 4'd15 - i[3:0];
            #1;
            check("reset_sweep.rn", rn_data, 32'h0);
            check("reset_sweep.rm", rm_data, 32'h0);
        end

        for (int i = 1; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // no write-to-read bypass: old value visible until the edge
        @(negedge clk);
        current_mode = M_USR; rd_we = 1'b1; rd_addr = 4'd3; rd_data = 32'h33; rn_addr = 4'd3;
        #1;
        check("nobypass.before", rn_data, 32'h0);
        @(posedge clk);
        #1;
        rd_we = 1'b0;
        #1;
        check("nobypass.after", rn_data, 32'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
